// File: rtl/mm_arbiter.sv
// Two-master round-robin arbiter and single-slave transaction sequencer.
// A saturating watchdog aborts any transaction the slave never acknowledges.
module mm_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m0_done,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        owner
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Abort fires on the edge where the counter shows TIMEOUT-1 elapsed cycles.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_q,    state_d;
    logic [7:0]  cnt_q,      cnt_d;
    logic        owner_q,    owner_d;
    logic        s_we_q,     s_we_d;
    logic [31:0] s_addr_q,   s_addr_d;
    logic [31:0] s_wdata_q,  s_wdata_d;
    logic        m0_done_q,  m0_done_d;
    logic        m1_done_q,  m1_done_d;
    logic        m0_err_q,   m0_err_d;
    logic        m1_err_q,   m1_err_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;

    logic        grant_s;
    logic        any_req_s;
    logic        pulse_s;
    logic        timeout_s;

    // Round-robin pick: on a tie the master that is not the current owner wins.
    always_comb begin
        grant_s   = 1'b0;
        any_req_s = m0_req | m1_req;
        pulse_s   = m0_done_q | m1_done_q;
        timeout_s = (cnt_q >= TO_LAST);
        if (m0_req && m1_req) begin
            grant_s = ~owner_q;
        end else if (m1_req) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state and datapath: IDLE holds off a grant while a done pulse is out.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        m0_done_d  = 1'b0;
        m1_done_d  = 1'b0;
        m0_err_d   = 1'b0;
        m1_err_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s && !pulse_s) begin
                    state_d   = ST_BUSY;
                    cnt_d     = 8'd0;
                    owner_d   = grant_s;
                    s_we_d    = grant_s ? m1_we    : m0_we;
                    s_addr_d  = grant_s ? m1_addr  : m0_addr;
                    s_wdata_d = grant_s ? m1_wdata : m0_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);
                if (s_ready) begin
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        m1_done_d = 1'b1;
                        if (!s_we_q) begin
                            m1_rdata_d = s_rdata;
                        end else begin
                            m1_rdata_d = m1_rdata_q;
                        end
                    end else begin
                        m0_done_d = 1'b1;
                        if (!s_we_q) begin
                            m0_rdata_d = s_rdata;
                        end else begin
                            m0_rdata_d = m0_rdata_q;
                        end
                    end
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        m1_done_d  = 1'b1;
                        m1_err_d   = 1'b1;
                        m1_rdata_d = 32'h0000_0000;
                    end else begin
                        m0_done_d  = 1'b1;
                        m0_err_d   = 1'b1;
                        m0_rdata_d = 32'h0000_0000;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; owner resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            owner_q    <= 1'b1;
            s_we_q     <= 1'b0;
            s_addr_q   <= 32'h0000_0000;
            s_wdata_q  <= 32'h0000_0000;
            m0_done_q  <= 1'b0;
            m1_done_q  <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m0_rdata_q <= 32'h0000_0000;
            m1_rdata_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            m0_done_q  <= m0_done_d;
            m1_done_q  <= m1_done_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign s_valid  = (state_q == ST_BUSY);
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign owner    = owner_q;
    assign m0_done  = m0_done_q;
    assign m1_done  = m1_done_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule
